mem_byte_bridge: RTL

Downstream of the multicycle RV32I control/datapath. Serves the core's 32-bit word memory port (mem_read/mem_write/mem_byte_enable/mem_resp) over an external 8-bit req/ack byte bus. Each CPU access becomes up to four sequential byte transfers, ascending byte offset. The bridge returns a single-cycle mem_resp when the access completes.

---
 rtl/mem_byte_bridge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_byte_bridge.sv
// Serves a 32-bit word memory port over an 8-bit req/ack byte bus, walking the
// enabled byte lanes in ascending order and returning a single-cycle mem_resp.
module mem_byte_bridge #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t        state;
  logic [3:0]    lanes_left;
  logic [31:0]   wdata_q;
  logic [CW-1:0] wait_cnt;

  logic [3:0]    start_mask;
  logic [3:0]    rest_mask;
  logic [1:0]    first_off;
  logic [1:0]    next_off;
  logic          timeout;

  // The byte offset comes from the lane walk, so the low address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    start_mask = mem_write ? mem_byte_enable : 4'b1111;
    first_off  = lowest(start_mask);
    rest_mask  = lanes_left & ~(4'b0001 << bus_addr[1:0]);
    next_off   = lowest(rest_mask);
    timeout    = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lanes_left <= 4'b0000;
      wdata_q    <= 32'd0;
      wait_cnt   <= '0;
      mem_rdata  <= 32'd0;
      mem_resp   <= 1'b0;
      mem_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 8'd0;
    end else begin
      mem_resp <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            bus_we     <= mem_write;
            wdata_q    <= mem_wdata;
            wait_cnt   <= '0;
            lanes_left <= start_mask;
            bus_addr   <= {mem_address[31:2], first_off};
            bus_wdata  <= mem_wdata[{first_off, 3'b000} +: 8];
            if (!mem_write) mem_rdata <= 32'd0;
            // An all-disabled write completes without touching the bus.
            if (start_mask == 4'b0000) begin
              state    <= RESP;
              mem_resp <= 1'b1;
            end else begin
              state   <= XFER;
              bus_req <= 1'b1;
            end
          end
        end
        XFER: begin
          if (bus_ack) begin
            if (!bus_we) mem_rdata[{bus_addr[1:0], 3'b000} +: 8] <= bus_rdata;
            wait_cnt   <= '0;
            lanes_left <= rest_mask;
            if (rest_mask != 4'b0000) begin
              bus_addr[1:0] <= next_off;
              bus_wdata     <= wdata_q[{next_off, 3'b000} +: 8];
            end else begin
              bus_req  <= 1'b0;
              state    <= RESP;
              mem_resp <= 1'b1;
            end
          end else if (timeout) begin
            bus_req  <= 1'b0;
            state    <= RESP;
            mem_resp <= 1'b1;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
